fifo_record_packer: RTL and testbench
=====================================

Name: fifo_record_packer

Overview:
- Write-domain front end of the dual-clock 80-bit record FIFO; sits directly upstream of its write port.
- Packs a 16-bit word stream (valid/ready) into 80-bit records: 4-bit count, 12-bit sequence number and 4 payload lanes.
- Drives the FIFO write_en/data_in pair and honours its full flag, so no record is ever lost or duplicated.

Parameters:
- PAD_WORD, 16'h0000, value placed in unfilled payload lanes of a partial record.
- TIMEOUT, 64, idle write_clk cycles before a partial record auto-flushes; 0 disables auto-flush (legal range 0..65535).

Ports:
- write_clk  in  1  write-domain clock; all state is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_data  in  16  upstream word.
- in_last  in  1  with an accepted word: close the record after this word.
- in_ready  out  1  word accepted on an edge where in_valid && in_ready.
- flush  in  1  single-cycle request to close the current partial record.
- fifo_full  in  1  FIFO full flag (write domain).
- fifo_write_en  out  1  record valid toward the FIFO.
- fifo_data  out  80  record toward the FIFO.
- idle  out  1  staging and output registers both empty.

Behaviour:
- Record format: [79:76] count (1..4), [75:64] seq, word lane i at [16i+15:16i]. Lane 0 is the first word. Unfilled lanes = PAD_WORD.
- Reset (async assert, sync release): fifo_write_en=0, fifo_data=0, in_ready=1, idle=1, seq=0, lane=0, idle counter=0. A partial record in flight is discarded.
- Staging register: lane index 0..3 and a complete flag.
  - An accepted word writes lane[lane], then lane increments.
  - The record becomes complete when lane 3 is written or in_last=1.
- flush: sets complete if lane>0 and not complete; ignored if staging is empty. flush in the same cycle as an accepted word includes that word, then completes.
- Auto-flush: the idle counter clears on every accepted word. It increments each cycle while staging is partial (lane>0, not complete) and no word is accepted. When it reaches TIMEOUT, it sets complete.
- Output register: fifo_write_en is the valid bit; fifo_data is registered.
  - Retire = fifo_write_en && !fifo_full. This is the same acceptance rule the FIFO uses.
  - While fifo_write_en=1 and not retired, fifo_data is held stable.
- Transfer staging->output on an edge where complete && (!fifo_write_en || retire).
  - The record's count and seq are loaded, seq increments (wraps 4095->0) and staging clears.
  - If a word is accepted on the same edge, it lands in lane 0 of the fresh record.
- in_ready = !complete || !fifo_write_en || !fifo_full. This is a combinational path from fifo_full; it is the only such path and is documented for timing.
- Latency: the record completes on the accept edge t; fifo_write_en is high from edge t+1; the FIFO writes at the first edge from t+2 with fifo_full=0.
- Throughput: 1 word/cycle sustained while fifo_full=0 (one record per 4 cycles).
- Backpressure: with fifo_full held high, at most one record waits in the output register and one complete record waits in staging. in_ready is then 0.
- idle = (lane==0) && !complete && !fifo_write_en.

Decomposition:
- Package fifo_pack_pkg:
  - REC_W=80, WORD_W=16, LANES=4, SEQ_W=12, CNT_W=4.
  - Field offsets.
  - record_t packed struct {count, seq, lanes[4]}.
- Single module; the staging/output logic is too tightly coupled to justify a sub-module.

Test Plan:
- 8 words 0x0001..0x0008 back-to-back, fifo_full=0 -> writes 80'h4000_0004_0003_0002_0001, then 80'h4001_0008_0007_0006_0005; in_ready stays 1 throughout.
- Words 0xAAAA, 0xBBBB with in_last on the 2nd; then a lone flush with empty staging -> one write 80'h2002_0000_0000_BBBB_AAAA (seq continuing from 2); flush produces nothing.
- fifo_full=1 for 10 cycles during a 12-word stream -> fifo_write_en held with fifo_data stable; in_ready drops once staging completes. After release, records seq 0,1,2 are written in order with no gaps or duplicates.
- Single word 0x1234 then idle, TIMEOUT=64 -> exactly 64 idle cycles later complete is set; write 80'h1000_0000_0000_0000_1234. With TIMEOUT=0 there is no write after 200 cycles.
- 4097 full records -> seq field of record 4095 = 0xFFF; record 4096 = 0x000.
- rst asserted mid-record (lane=2) while fifo_write_en=1 -> fifo_write_en=0 immediately (asynchronously). After release, the next record has seq 0 and contains only post-reset words.

Source files
------------

// File: rtl/fifo_pack_pkg.sv
// Shared widths, field offsets and the record layout for the 80-bit record FIFO.
// The packer fills the record type; the downstream FIFO stores it as a flat vector.
package fifo_pack_pkg;

    localparam int REC_W  = 80;
    localparam int WORD_W = 16;
    localparam int LANES  = 4;
    localparam int SEQ_W  = 12;
    localparam int CNT_W  = 4;

    localparam int LANE_LSB = 0;
    localparam int SEQ_LSB  = LANES * WORD_W;
    localparam int CNT_LSB  = SEQ_LSB + SEQ_W;

    typedef logic [LANES-1:0][WORD_W-1:0] lanes_t;

    // Lane 0 sits in the least significant bits, so it is the first word of the record.
    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [SEQ_W-1:0] seq;
        lanes_t           lanes;
    } record_t;

    function automatic record_t pack_record(input logic [CNT_W-1:0] count,
                                            input logic [SEQ_W-1:0] seq,
                                            input lanes_t           lanes);
        record_t rec;
        rec.count = count;
        rec.seq   = seq;
        rec.lanes = lanes;
        return rec;
    endfunction

endpackage

// File: rtl/fifo_record_packer.sv
// Write-side front end of the record FIFO: packs 16-bit words into 80-bit records
// through a staging register and an output register that holds while the FIFO is full.
module fifo_record_packer
    import fifo_pack_pkg::*;
#(
    parameter logic [15:0] PAD_WORD = 16'h0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic              write_clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [15:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              flush,
    input  logic              fifo_full,
    output logic              fifo_write_en,
    output logic [REC_W-1:0]  fifo_data,
    output logic              idle
);

    localparam logic        TO_EN     = (TIMEOUT != 32'd0);
    localparam logic [15:0] TIMEOUT_W = TIMEOUT[15:0];

    // fill_q counts staged words (0..4); a value of 4 only ever coexists with complete_q.
    lanes_t             lanes_q, lanes_d;
    logic [2:0]         fill_q, fill_d;
    logic               complete_q, complete_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [15:0]        idle_cnt_q, idle_cnt_d;
    logic               wen_q, wen_d;
    record_t            data_q, data_d;

    logic               accept_s;
    logic               retire_s;
    logic               xfer_s;
    logic [15:0]        idle_inc_s;

    // in_ready is the one combinational path from fifo_full; every other output is a flop.
    assign in_ready      = !complete_q || !wen_q || !fifo_full;
    assign accept_s      = in_valid && in_ready;
    assign retire_s      = wen_q && !fifo_full;
    assign xfer_s        = complete_q && (!wen_q || retire_s);
    assign fifo_write_en = wen_q;
    assign fifo_data     = data_q;
    assign idle          = (fill_q == 3'd0) && !complete_q && !wen_q;

    // Next-state for the staging record, the output record and the idle timer.
    always_comb begin
        lanes_d    = lanes_q;
        fill_d     = fill_q;
        complete_d = complete_q;
        seq_d      = seq_q;
        idle_cnt_d = idle_cnt_q;
        wen_d      = wen_q;
        data_d     = data_q;
        idle_inc_s = idle_cnt_q + 16'd1;

        if (xfer_s) begin
            wen_d      = 1'b1;
            data_d     = pack_record({1'b0, fill_q}, seq_q, lanes_q);
            seq_d      = seq_q + 12'd1;
            lanes_d    = {LANES{PAD_WORD}};
            fill_d     = 3'd0;
            complete_d = 1'b0;
        end else if (retire_s) begin
            wen_d = 1'b0;
        end else begin
            wen_d = wen_q;
        end

        // An accepted word always lands in the record left over after any transfer above.
        if (accept_s) begin
            lanes_d[fill_d[1:0]] = in_data;
            fill_d               = fill_d + 3'd1;
            idle_cnt_d           = 16'd0;
            complete_d           = (fill_d == 3'd4) || in_last || flush;
        end else if ((fill_d != 3'd0) && !complete_d) begin
            idle_cnt_d = idle_inc_s;
            complete_d = flush || (TO_EN && (idle_inc_s == TIMEOUT_W));
        end else begin
            idle_cnt_d = 16'd0;
        end
    end

    // State registers; reset drops any partial record and restarts the sequence.
    always_ff @(posedge write_clk or posedge rst) begin
        if (rst) begin
            lanes_q    <= {LANES{PAD_WORD}};
            fill_q     <= 3'd0;
            complete_q <= 1'b0;
            seq_q      <= 12'd0;
            idle_cnt_q <= 16'd0;
            wen_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            lanes_q    <= lanes_d;
            fill_q     <= fill_d;
            complete_q <= complete_d;
            seq_q      <= seq_d;
            idle_cnt_q <= idle_cnt_d;
            wen_q      <= wen_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_fifo_record_packer.sv
// Directed bench for fifo_record_packer: hand-computed records compared against
// everything the FIFO would accept, plus a TIMEOUT=0 twin for the no-auto-flush case.
module tb_fifo_record_packer;

    logic        write_clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        flush;
    logic        fifo_full;
    logic        fifo_write_en;
    logic [79:0] fifo_data;
    logic        idle;

    logic        in_ready0;
    logic        fifo_write_en0;
    logic [79:0] fifo_data0;
    logic        idle0;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int wcnt0  = 0;
    logic [79:0] wq[$];

    always #5 write_clk = ~write_clk;

    fifo_record_packer #(.PAD_WORD(16'h0000), .TIMEOUT(64)) dut (
        .write_clk(write_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .flush(flush), .fifo_full(fifo_full),
        .fifo_write_en(fifo_write_en), .fifo_data(fifo_data), .idle(idle)
    );

    fifo_record_packer #(.PAD_WORD(16'h0000), .TIMEOUT(0)) dut0 (
        .write_clk(write_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready0), .flush(flush), .fifo_full(fifo_full),
        .fifo_write_en(fifo_write_en0), .fifo_data(fifo_data0), .idle(idle0)
    );

    // Record every write the FIFO would take on this edge.
    always @(posedge write_clk) begin
        if (!rst && fifo_write_en && !fifo_full) wq.push_back(fifo_data);
        if (!rst && fifo_write_en0 && !fifo_full) wcnt0 <= wcnt0 + 1;
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] getq(input int i);
        if (i < wq.size()) return wq[i];
        return {80{1'bx}};
    endfunction

    // Present one word from a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [15:0] d, input logic l, input logic f);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1; in_data = d; in_last = l; flush = f;
        while (!ok && n < 200) begin
            #4;
            ok = in_ready;
            n++;
            @(negedge write_clk);
        end
        if (n > 1) stalls++;
        chk("send_accept", {79'd0, ok}, 80'd1);
        in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; flush = 1'b0; fifo_full = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge write_clk);
        rst = 1'b0;
        @(negedge write_clk);
    endtask

    logic [79:0] snap;
    int base;
    int base0;

    initial begin
        do_reset();
        chk("reset_wen",   {79'd0, fifo_write_en}, 80'd0);
        chk("reset_data",  fifo_data, 80'd0);
        chk("reset_ready", {79'd0, in_ready}, 80'd1);
        chk("reset_idle",  {79'd0, idle}, 80'd1);

        // Two full records back-to-back.
        base = wq.size(); stalls = 0;
        for (int i = 1; i <= 8; i++) send(i[15:0], 1'b0, 1'b0);
        repeat (4) @(negedge write_clk);
        chk("t1_count", wq.size() - base, 80'd2);
        chk("t1_rec0", getq(base), 80'h4000_0004_0003_0002_0001);
        chk("t1_rec1", getq(base + 1), 80'h4001_0008_0007_0006_0005);
        chk("t1_no_stall", stalls, 80'd0);

        // in_last closes a short record; a flush on empty staging does nothing.
        base = wq.size();
        send(16'hAAAA, 1'b0, 1'b0);
        send(16'hBBBB, 1'b1, 1'b0);
        repeat (3) @(negedge write_clk);
        flush = 1'b1;
        @(negedge write_clk);
        flush = 1'b0;
        repeat (5) @(negedge write_clk);
        chk("t2_count", wq.size() - base, 80'd1);
        chk("t2_rec", getq(base), 80'h2002_0000_0000_BBBB_AAAA);
        chk("t2_idle", {79'd0, idle}, 80'd1);

        // Backpressure: fifo_full high for 10 cycles in the middle of a 12-word stream.
        do_reset();
        base = wq.size();
        fork
            begin
                for (int i = 1; i <= 12; i++) send(i[15:0], 1'b0, 1'b0);
            end
            begin
                repeat (3) @(negedge write_clk);
                fifo_full = 1'b1;
                repeat (2) @(negedge write_clk);
                chk("t3_wen_up", {79'd0, fifo_write_en}, 80'd1);
                snap = fifo_data;
                chk("t3_first", snap, 80'h4000_0004_0003_0002_0001);
                for (int k = 0; k < 7; k++) begin
                    @(negedge write_clk);
                    chk("t3_hold_wen", {79'd0, fifo_write_en}, 80'd1);
                    chk("t3_hold_data", fifo_data, snap);
                end
                chk("t3_ready_low", {79'd0, in_ready}, 80'd0);
                @(negedge write_clk);
                fifo_full = 1'b0;
            end
        join
        repeat (20) @(negedge write_clk);
        chk("t3_count", wq.size() - base, 80'd3);
        chk("t3_rec0", getq(base),     80'h4000_0004_0003_0002_0001);
        chk("t3_rec1", getq(base + 1), 80'h4001_0008_0007_0006_0005);
        chk("t3_rec2", getq(base + 2), 80'h4002_000C_000B_000A_0009);

        // Auto-flush after exactly 64 idle cycles; the TIMEOUT=0 twin never flushes.
        do_reset();
        base = wq.size(); base0 = wcnt0;
        send(16'h1234, 1'b0, 1'b0);
        repeat (64) @(negedge write_clk);
        chk("t4_not_yet", {79'd0, fifo_write_en}, 80'd0);
        @(negedge write_clk);
        chk("t4_wen", {79'd0, fifo_write_en}, 80'd1);
        chk("t4_data", fifo_data, 80'h1000_0000_0000_0000_1234);
        repeat (140) @(negedge write_clk);
        chk("t4_count", wq.size() - base, 80'd1);
        chk("t4_nto_writes", wcnt0 - base0, 80'd0);
        chk("t4_nto_idle", {79'd0, idle0}, 80'd0);

        // Sequence number wrap across 4097 records.
        do_reset();
        base = wq.size();
        for (int i = 0; i < 4097 * 4; i++) send(i[15:0], 1'b0, 1'b0);
        repeat (4) @(negedge write_clk);
        chk("t5_count", wq.size() - base, 80'd4097);
        chk("t5_rec4095", getq(base + 4095), 80'h4FFF_3FFF_3FFE_3FFD_3FFC);
        chk("t5_rec4096", getq(base + 4096), 80'h4000_4003_4002_4001_4000);

        // Asynchronous reset with a held output record and lane 2 staged.
        do_reset();
        fifo_full = 1'b1;
        send(16'h0011, 1'b0, 1'b0);
        send(16'h0012, 1'b0, 1'b0);
        send(16'h0013, 1'b0, 1'b0);
        send(16'h0014, 1'b0, 1'b0);
        send(16'h0021, 1'b0, 1'b0);
        send(16'h0022, 1'b0, 1'b0);
        chk("t6_wen_before", {79'd0, fifo_write_en}, 80'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_wen_async", {79'd0, fifo_write_en}, 80'd0);
        chk("t6_data_async", fifo_data, 80'd0);
        chk("t6_idle_async", {79'd0, idle}, 80'd1);
        @(negedge write_clk);
        rst = 1'b0; fifo_full = 1'b0;
        base = wq.size();
        send(16'h0031, 1'b0, 1'b0);
        send(16'h0032, 1'b0, 1'b0);
        send(16'h0033, 1'b0, 1'b0);
        send(16'h0034, 1'b0, 1'b0);
        repeat (4) @(negedge write_clk);
        chk("t6_count", wq.size() - base, 80'd1);
        chk("t6_rec", getq(base), 80'h4000_0034_0033_0032_0031);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
